// File: rtl/sa_os_array_pkg.sv
// Shared types and helpers for the output-stationary systolic array.
package sa_pkg;

    // Controller states: a pass walks IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Zero-injection cycles needed after the last beat so that it reaches PE(N-1,N-1).
    function automatic int flush_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/sa_os_array_if.sv
// Bundle of the pass-control, operand-input and result-output signals of sa_os_array.
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high. The source holds valid and its payload steady until that edge.
// in_ready is high for the whole of LOAD. Cycles in LOAD without in_valid are
// bubbles. out_valid is high for the whole of DRAIN. out_data, out_row and
// out_last do not change while out_valid=1 and out_ready=0.
interface sa_os_array_if #(
    parameter int N       = 8,
    parameter int WIDTH   = 8,
    parameter int C_WIDTH = 32,
    parameter int K_W     = 16
) ();
    localparam int RW = $clog2(N);

    logic                 start;
    logic [K_W-1:0]       k_len;
    logic                 acc_clear;
    logic                 in_valid;
    logic                 in_ready;
    logic [N*WIDTH-1:0]   act_in;
    logic [N*WIDTH-1:0]   wgt_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [N*C_WIDTH-1:0] out_data;
    logic [RW-1:0]        out_row;
    logic                 out_last;
    logic                 busy;
    logic                 done;
    sa_pkg::state_t       state;

    modport master (
        output start, k_len, acc_clear, in_valid, act_in, wgt_in, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_last, busy, done, state
    );

    modport slave (
        input  start, k_len, acc_clear, in_valid, act_in, wgt_in, out_ready,
        output in_ready, out_valid, out_data, out_row, out_last, busy, done, state
    );
endinterface

// File: rtl/sa_os_array_pe.sv
// One multiply-accumulate cell: forwards act right and wgt down, and accumulates act*wgt.
module sa_pe #(
    parameter int WIDTH   = 8,
    parameter int C_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clr,
    input  logic [WIDTH-1:0]   act_in,
    input  logic [WIDTH-1:0]   wgt_in,
    output logic [WIDTH-1:0]   act_out,
    output logic [WIDTH-1:0]   wgt_out,
    output logic [C_WIDTH-1:0] acc
);
    logic signed [2*WIDTH-1:0] act_x;
    logic signed [2*WIDTH-1:0] wgt_x;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [C_WIDTH-1:0] prod_x;

    // Operands are sign-extended first so the low 2*WIDTH bits hold the full signed product.
    assign act_x  = (2*WIDTH)'($signed(act_in));
    assign wgt_x  = (2*WIDTH)'($signed(wgt_in));
    assign prod   = act_x * wgt_x;
    assign prod_x = C_WIDTH'(prod);

    // Forwarding registers and the accumulator. A clear wins over the incoming product,
    // which is always zero while a clear can be issued.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act_out <= '0;
            wgt_out <= '0;
            acc     <= '0;
        end else begin
            act_out <= act_in;
            wgt_out <= wgt_in;
            if (clr) begin
                acc <= '0;
            end else begin
                acc <= acc + prod_x;
            end
        end
    end
endmodule

// File: rtl/sa_os_array.sv
// N x N output-stationary systolic array with input skew, pass controller and row drain.
module sa_os_array
    import sa_pkg::*;
#(
    parameter int N       = 8,
    parameter int WIDTH   = 8,
    parameter int C_WIDTH = 32,
    parameter int K_W     = 16
) (
    input  logic          clk,
    input  logic          rstn,
    sa_os_array_if.slave  io
);
    localparam int RW = $clog2(N);
    localparam int FL = flush_len(N);
    localparam int FW = $clog2(FL + 1);

    state_t         state;
    state_t         state_nx;
    logic [K_W-1:0] k_len_r;
    logic [K_W-1:0] beat_cnt;
    logic [FW-1:0]  flush_cnt;
    logic [RW-1:0]  row_cnt;
    logic           done_r;
    logic           in_ready_c;
    logic           out_valid_c;

    logic           beat_acc;
    logic           last_beat;
    logic           flush_end;
    logic           last_row;
    logic           row_hs;
    logic           acc_clr;

    assign beat_acc  = (state == LOAD) && io.in_valid;
    assign last_beat = beat_acc && ((beat_cnt + K_W'(1)) == k_len_r);
    assign flush_end = (state == FLUSH) && (flush_cnt == FW'(FL - 1));
    assign last_row  = (row_cnt == RW'(N - 1));
    assign row_hs    = (state == DRAIN) && io.out_ready;
    assign acc_clr   = (state == IDLE) && io.start && io.acc_clear;

    // Controller state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs of the controller.
    always_comb begin
        state_nx    = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                if (io.start) begin
                    state_nx = (io.k_len != '0) ? LOAD : DRAIN;
                end
            end
            LOAD: begin
                in_ready_c = 1'b1;
                if (last_beat) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_end) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                out_valid_c = 1'b1;
                if (row_hs && last_row) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Pass bookkeeping: captured length, beat / flush / row counters and the done pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k_len_r   <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row_cnt   <= '0;
            done_r    <= 1'b0;
        end else begin
            done_r <= row_hs && last_row;
            case (state)
                IDLE: begin
                    if (io.start) begin
                        k_len_r  <= io.k_len;
                        beat_cnt <= '0;
                        row_cnt  <= '0;
                    end
                end
                LOAD: begin
                    if (beat_acc) begin
                        beat_cnt <= beat_cnt + K_W'(1);
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_end ? '0 : flush_cnt + FW'(1);
                end
                DRAIN: begin
                    if (row_hs) begin
                        row_cnt <= last_row ? '0 : row_cnt + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Skew: lane i passes through i+1 registers, so beat k reaches PE(i,0) and PE(0,i)
    // i cycles after lane 0 does. Non-beat cycles push zeros in.
    logic [WIDTH-1:0] act_edge [N];
    logic [WIDTH-1:0] wgt_edge [N];

    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [WIDTH-1:0] act_dly [i+1];
        logic [WIDTH-1:0] wgt_dly [i+1];

        // Delay line for activation lane i and weight lane i.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int d = 0; d <= i; d++) begin
                    act_dly[d] <= '0;
                    wgt_dly[d] <= '0;
                end
            end else begin
                act_dly[0] <= beat_acc ? io.act_in[i*WIDTH +: WIDTH] : '0;
                wgt_dly[0] <= beat_acc ? io.wgt_in[i*WIDTH +: WIDTH] : '0;
                for (int d = 1; d <= i; d++) begin
                    act_dly[d] <= act_dly[d-1];
                    wgt_dly[d] <= wgt_dly[d-1];
                end
            end
        end

        assign act_edge[i] = act_dly[i];
        assign wgt_edge[i] = wgt_dly[i];
    end

    // PE grid: act flows along rows, wgt flows down columns.
    logic [WIDTH-1:0]   act_fwd [N][N];
    logic [WIDTH-1:0]   wgt_fwd [N][N];
    logic [C_WIDTH-1:0] acc_arr [N][N];

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [WIDTH-1:0] a_src;
            logic [WIDTH-1:0] w_src;

            if (j == 0) begin : g_a_edge
                assign a_src = act_edge[i];
            end else begin : g_a_fwd
                assign a_src = act_fwd[i][j-1];
            end

            if (i == 0) begin : g_w_edge
                assign w_src = wgt_edge[j];
            end else begin : g_w_fwd
                assign w_src = wgt_fwd[i-1][j];
            end

            sa_pe #(
                .WIDTH   (WIDTH),
                .C_WIDTH (C_WIDTH)
            ) u_pe (
                .clk     (clk),
                .rstn    (rstn),
                .clr     (acc_clr),
                .act_in  (a_src),
                .wgt_in  (w_src),
                .act_out (act_fwd[i][j]),
                .wgt_out (wgt_fwd[i][j]),
                .acc     (acc_arr[i][j])
            );
        end
    end

    // Result row selected by the drain counter; it only moves on a handshake, so it holds under stall.
    for (genvar j = 0; j < N; j++) begin : g_out
        assign io.out_data[j*C_WIDTH +: C_WIDTH] = acc_arr[row_cnt][j];
    end

    assign io.in_ready  = in_ready_c;
    assign io.out_valid = out_valid_c;
    assign io.out_row   = row_cnt;
    assign io.out_last  = (state == DRAIN) && last_row;
    assign io.busy      = (state != IDLE);
    assign io.done      = done_r;
    assign io.state     = state;
endmodule
